// File: rtl/div_sched_pkg.sv
// Shared types for the divider scheduler: controller state encoding and result field placement.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned QUO_LSB = 0;

  // Remainder occupies the upper half of the packed result.
  function automatic int unsigned rem_lsb(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring signed divider datapath: operand magnitudes, one quotient bit per step, sign fix-up.
module div_iter_core
  import div_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  output logic               last,
  output logic [2*WIDTH-1:0] result,
  output logic               dz
);

  localparam int unsigned CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned REM_LSB = rem_lsb(WIDTH);

  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dz_q, dz_d;
  logic [WIDTH:0]     trial, diff;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    dz_d   = dz_q;
    trial  = {rem_q, quo_q[WIDTH-1]};
    // diff[WIDTH] is the borrow: set means the trial subtraction must be undone.
    diff   = trial - {1'b0, dvs_q};

    if (load) begin
      quo_d  = num1[WIDTH-1] ? -num1 : num1;
      dvs_d  = num2[WIDTH-1] ? -num2 : num2;
      rem_d  = '0;
      qneg_d = num1[WIDTH-1] ^ num2[WIDTH-1];
      rneg_d = num1[WIDTH-1];
      cnt_d  = CW'(WIDTH - 1);
      res_d  = '0;
      dz_d   = (num2 == '0);
      if (num2 == '0) begin
        res_d[REM_LSB +: WIDTH] = num1;
        res_d[QUO_LSB +: WIDTH] = '1;
      end
    end else if (step) begin
      rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q - 1'b1;
    end else if (fix) begin
      res_d[REM_LSB +: WIDTH] = rneg_q ? -rem_q : rem_q;
      res_d[QUO_LSB +: WIDTH] = qneg_q ? -quo_q : quo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      dz_q   <= dz_d;
    end
  end

  assign last   = (cnt_q == '0);
  assign result = res_q;
  assign dz     = dz_q;

endmodule

// File: rtl/div_sched_ctrl.sv
// Round-robin scheduler for one shared signed divider with valid/ready request and response ports.
// Defining DIV_SCHED_STATS_EN adds the stat_grants per-requester accept counters.
module div_sched_ctrl
  import div_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_num1,
  input  logic [NREQ*WIDTH-1:0] req_num2,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_result,
  output logic                  rsp_dz,
  output logic                  busy
`ifdef DIV_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]    stat_grants
`endif
);

  localparam int unsigned IDW = (NREQ > 2) ? 2 : 1;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     win;
  logic               win_valid;
  int unsigned        idx;
  logic [WIDTH-1:0]   num1_sel, num2_sel;
  logic               load, step, fix, last;
  logic [2*WIDTH-1:0] core_result;
  logic               core_dz;

  // Scan from the requester just after the last winner, wrapping, first valid wins.
  always_comb begin
    win       = ptr_q;
    win_valid = 1'b0;
    idx       = 0;
    num1_sel  = '0;
    num2_sel  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_valid && req_valid[idx]) begin
        win_valid = 1'b1;
        win       = IDW'(idx);
        num1_sel  = req_num1[idx*WIDTH +: WIDTH];
        num2_sel  = req_num2[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    req_ready = '0;
    rsp_valid = '0;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          req_ready[win] = 1'b1;
          load           = 1'b1;
          ptr_d          = win;
          id_d           = win;
          state_d        = (num2_sel == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        step = 1'b1;
        if (last) state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  div_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .fix    (fix),
    .num1   (num1_sel),
    .num2   (num2_sel),
    .last   (last),
    .result (core_result),
    .dz     (core_dz)
  );

  assign rsp_result = (state_q == DONE) ? core_result : '0;
  assign rsp_dz     = (state_q == DONE) ? core_dz : 1'b0;
  assign busy       = (state_q != IDLE);

`ifdef DIV_SCHED_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];
  logic [15:0] grant_cnt_d [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (load && (win == IDW'(i)) && (grant_cnt_q[i] != 16'hFFFF))
        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      stat_grants[i*16 +: 16] = grant_cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (reset) grant_cnt_q[i] <= '0;
      else       grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end
`endif

endmodule
